// File: rtl/arb_grant_root_if.sv
// Handshake and grant bus between the arbitration tree root, the grant root
// responder and the downstream transfer engine.
interface arb_grant_root_if #(
    parameter int TAG_SZ     = 5,
    parameter int NUM_LEAVES = 32,
    parameter int CNT_SZ     = 32
);
    logic                  en;
    logic [TAG_SZ-1:0]     tag;
    logic                  rdy;
    logic                  ack;
    logic [TAG_SZ-1:0]     grant_tag;
    logic                  grant_vld;
    logic [NUM_LEAVES-1:0] grant_onehot;
    logic                  done;
    logic                  timeout_err;
    logic                  bad_tag;
    logic [CNT_SZ-1:0]     grant_cnt;

    // Tree / transfer-engine side.
    modport master (
        output en, tag, rdy, done,
        input  ack, grant_tag, grant_vld, grant_onehot, timeout_err, bad_tag, grant_cnt
    );

    // Grant root responder side.
    modport slave (
        input  en, tag, rdy, done,
        output ack, grant_tag, grant_vld, grant_onehot, timeout_err, bad_tag, grant_cnt
    );
endinterface

// File: rtl/arb_grant_root.sv
// Root responder of the tag arbitration tree. Accepts one tag per
// transaction, holds it as the active grant until the transfer engine
// signals completion or the BUSY timer expires, and reports statistics.
module arb_grant_root #(
    parameter int TAG_SZ     = 5,
    parameter int NUM_LEAVES = 32,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_SZ     = 32
) (
    input  logic              clk,
    input  logic              rst,
    arb_grant_root_if.slave   bus
);

    // Timer counts 0..TIMEOUT-1 while BUSY; at least one bit wide.
    localparam int TMR_W_RAW = $clog2(TIMEOUT + 1);
    localparam int TMR_W     = (TMR_W_RAW < 1) ? 1 : TMR_W_RAW;
    localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TMR_W-1:0]  TO_LAST  = TMR_W'(TO_LAST_I);
    localparam logic [TAG_SZ:0]   LEAVES_W = (TAG_SZ + 1)'(NUM_LEAVES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [TMR_W-1:0]      r_timer;
    logic [TMR_W-1:0]      w_timer_nxt;
    logic [TAG_SZ-1:0]     r_grant_tag;
    logic [TAG_SZ-1:0]     w_grant_tag_nxt;
    logic                  r_grant_vld;
    logic                  w_grant_vld_nxt;
    logic [NUM_LEAVES-1:0] r_onehot;
    logic [NUM_LEAVES-1:0] w_onehot_nxt;
    logic                  r_timeout_err;
    logic                  w_timeout_err_nxt;
    logic                  r_bad_tag;
    logic                  w_bad_tag_nxt;
    logic [CNT_SZ-1:0]     r_cnt;
    logic [CNT_SZ-1:0]     w_cnt_nxt;

    logic                  w_ack;
    logic                  w_accept;
    logic                  w_tag_ok;
    logic                  w_timeout_hit;
    logic [NUM_LEAVES-1:0] w_dec;

    // Combinational ack so it ripples back through the tree in the same cycle.
    assign w_ack         = (r_state == IDLE) && bus.en && bus.rdy;
    assign w_accept      = w_ack && bus.rdy;
    assign w_tag_ok      = ({1'b0, bus.tag} < LEAVES_W);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_timer == TO_LAST);

    // One-hot decode of the incoming tag, captured on accept.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            w_dec[i] = ({1'b0, bus.tag} == (TAG_SZ + 1)'(i));
        end
    end

    // Next-state and next-register values; pulses default low every cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_grant_tag_nxt   = r_grant_tag;
        w_grant_vld_nxt   = r_grant_vld;
        w_onehot_nxt      = r_onehot;
        w_timeout_err_nxt = 1'b0;
        w_bad_tag_nxt     = 1'b0;
        w_cnt_nxt         = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_tag_ok) begin
                        w_state_nxt     = BUSY;
                        w_timer_nxt     = '0;
                        w_grant_tag_nxt = bus.tag;
                        w_grant_vld_nxt = 1'b1;
                        w_onehot_nxt    = w_dec;
                        if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
                    end else begin
                        // Upstream already saw the ack: drop the tag, flag it.
                        w_bad_tag_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                w_timer_nxt = r_timer + 1'b1;
                // Completion has priority over a coincident timeout.
                if (bus.done) begin
                    w_state_nxt     = IDLE;
                    w_grant_vld_nxt = 1'b0;
                    w_onehot_nxt    = '0;
                end else if (w_timeout_hit) begin
                    w_state_nxt       = IDLE;
                    w_grant_vld_nxt   = 1'b0;
                    w_onehot_nxt      = '0;
                    w_timeout_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Grant, timer, pulse and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer       <= '0;
            r_grant_tag   <= '0;
            r_grant_vld   <= 1'b0;
            r_onehot      <= '0;
            r_timeout_err <= 1'b0;
            r_bad_tag     <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_timer       <= w_timer_nxt;
            r_grant_tag   <= w_grant_tag_nxt;
            r_grant_vld   <= w_grant_vld_nxt;
            r_onehot      <= w_onehot_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_bad_tag     <= w_bad_tag_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign bus.ack          = w_ack;
    assign bus.grant_tag    = r_grant_tag;
    assign bus.grant_vld    = r_grant_vld;
    assign bus.grant_onehot = r_onehot;
    assign bus.timeout_err  = r_timeout_err;
    assign bus.bad_tag      = r_bad_tag;
    assign bus.grant_cnt    = r_cnt;

endmodule

// File: tb/tb_arb_grant_root.sv
// Directed bench for arb_grant_root: 20 agents, 16-cycle timeout, 2-bit counter.
module tb_arb_grant_root;

    localparam int TAG_SZ     = 5;
    localparam int NUM_LEAVES = 20;
    localparam int TIMEOUT    = 16;
    localparam int CNT_SZ     = 2;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    arb_grant_root_if #(.TAG_SZ(TAG_SZ), .NUM_LEAVES(NUM_LEAVES), .CNT_SZ(CNT_SZ)) bus_if ();

    arb_grant_root #(
        .TAG_SZ(TAG_SZ), .NUM_LEAVES(NUM_LEAVES), .TIMEOUT(TIMEOUT), .CNT_SZ(CNT_SZ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected counter values for five grants from reset with a 2-bit counter.
    logic [31:0] sat_exp [5] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
    logic [4:0]  sat_tag [5] = '{5'd0, 5'd19, 5'd4, 5'd11, 5'd1};

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.en = 1'b0; bus_if.rdy = 1'b0; bus_if.tag = '0; bus_if.done = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_ack", bus_if.ack, 0);
        chk("rst_vld", bus_if.grant_vld, 0);
        chk("rst_tag", bus_if.grant_tag, 0);
        chk("rst_onehot", bus_if.grant_onehot, 0);
        chk("rst_cnt", bus_if.grant_cnt, 0);
        chk("rst_to", bus_if.timeout_err, 0);
        chk("rst_bad", bus_if.bad_tag, 0);
        rst = 1'b0;
        tick();

        // Grant tag 7: ack same cycle, registered grant next cycle
        bus_if.en = 1'b1; bus_if.rdy = 1'b1; bus_if.tag = 5'd7;
        #1;
        chk("g7_ack", bus_if.ack, 1);
        tick();
        chk("g7_vld", bus_if.grant_vld, 1);
        chk("g7_tag", bus_if.grant_tag, 7);
        chk("g7_onehot", bus_if.grant_onehot, 32'h0000_0080);
        chk("g7_cnt", bus_if.grant_cnt, 1);

        // BUSY ignores a waiting tag
        bus_if.tag = 5'd3;
        #1;
        chk("busy_ack0", bus_if.ack, 0);
        tick();
        chk("busy_ack1", bus_if.ack, 0);
        chk("busy_vld", bus_if.grant_vld, 1);
        bus_if.done = 1'b1;
        tick();
        bus_if.done = 1'b0;
        #1;
        chk("done_vld", bus_if.grant_vld, 0);
        chk("done_onehot", bus_if.grant_onehot, 0);
        chk("reack", bus_if.ack, 1);
        tick();
        chk("g3_vld", bus_if.grant_vld, 1);
        chk("g3_tag", bus_if.grant_tag, 3);
        chk("g3_onehot", bus_if.grant_onehot, 32'h0000_0008);
        chk("g3_cnt", bus_if.grant_cnt, 2);
        bus_if.rdy = 1'b0;
        bus_if.done = 1'b1;
        tick();
        bus_if.done = 1'b0;
        chk("rel3_vld", bus_if.grant_vld, 0);

        // done in IDLE is ignored
        bus_if.done = 1'b1;
        tick();
        bus_if.done = 1'b0;
        chk("idle_done_to", bus_if.timeout_err, 0);
        chk("idle_done_vld", bus_if.grant_vld, 0);

        // Out-of-range tags: consumed, flagged, no grant
        bus_if.rdy = 1'b1; bus_if.tag = 5'd25;
        #1;
        chk("bad25_ack", bus_if.ack, 1);
        tick();
        bus_if.rdy = 1'b0;
        chk("bad25_pulse", bus_if.bad_tag, 1);
        chk("bad25_vld", bus_if.grant_vld, 0);
        chk("bad25_cnt", bus_if.grant_cnt, 2);
        tick();
        chk("bad25_pulse_end", bus_if.bad_tag, 0);
        bus_if.rdy = 1'b1; bus_if.tag = 5'd20;
        tick();
        bus_if.rdy = 1'b0;
        chk("bad20_pulse", bus_if.bad_tag, 1);
        chk("bad20_vld", bus_if.grant_vld, 0);
        chk("bad20_cnt", bus_if.grant_cnt, 2);

        // Timeout: error pulse 16 cycles after grant_vld rises
        bus_if.rdy = 1'b1; bus_if.tag = 5'd2;
        tick();
        bus_if.rdy = 1'b0;
        chk("to_vld", bus_if.grant_vld, 1);
        chk("to_cnt", bus_if.grant_cnt, 3);
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            chk("to_wait_err", bus_if.timeout_err, 0);
            chk("to_wait_vld", bus_if.grant_vld, 1);
        end
        tick();
        chk("to_err", bus_if.timeout_err, 1);
        chk("to_vld_drop", bus_if.grant_vld, 0);
        tick();
        chk("to_err_end", bus_if.timeout_err, 0);

        // done on the timeout cycle wins: no error
        bus_if.rdy = 1'b1; bus_if.tag = 5'd2;
        tick();
        bus_if.rdy = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) tick();
        chk("tod_vld_pre", bus_if.grant_vld, 1);
        bus_if.done = 1'b1;
        tick();
        bus_if.done = 1'b0;
        chk("tod_err", bus_if.timeout_err, 0);
        chk("tod_vld", bus_if.grant_vld, 0);
        tick();
        chk("tod_err_late", bus_if.timeout_err, 0);

        // en low blocks accept; raising it acks the same cycle
        bus_if.en = 1'b0; bus_if.rdy = 1'b1; bus_if.tag = 5'd5;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("en0_ack", bus_if.ack, 0);
            chk("en0_vld", bus_if.grant_vld, 0);
        end
        bus_if.en = 1'b1;
        #1;
        chk("en1_ack", bus_if.ack, 1);
        tick();
        bus_if.rdy = 1'b0;
        chk("en1_vld", bus_if.grant_vld, 1);
        chk("en1_tag", bus_if.grant_tag, 5);

        // Asynchronous reset mid-BUSY clears before the next edge
        rst = 1'b1;
        #1;
        chk("arst_vld", bus_if.grant_vld, 0);
        chk("arst_onehot", bus_if.grant_onehot, 0);
        chk("arst_cnt", bus_if.grant_cnt, 0);
        chk("arst_to", bus_if.timeout_err, 0);
        tick();
        rst = 1'b0;
        tick();

        // Counter saturation over five grants
        for (int g = 0; g < 5; g++) begin
            bus_if.rdy = 1'b1; bus_if.tag = sat_tag[g];
            tick();
            bus_if.rdy = 1'b0;
            chk("sat_cnt", bus_if.grant_cnt, sat_exp[g]);
            if (g == 1) chk("g19_onehot", bus_if.grant_onehot, 32'h0008_0000);
            bus_if.done = 1'b1;
            tick();
            bus_if.done = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
